// File: rtl/fifo_fill_control_strided_pkg.sv
// Shared definitions for the strided FIFO fill controller: FSM encoding,
// default widths and the output-dimension helper used during SETUP.
package fifo_fill_pkg;

  localparam int DEFAULT_ADDR_W = 14;
  localparam int DEFAULT_DIM_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Number of valid window positions along one axis; 0 for degenerate inputs.
  function automatic logic [31:0] outDim(input logic [31:0] dim,
                                         input logic [31:0] k,
                                         input logic [31:0] s);
    if (s == 32'd0 || k > dim) return 32'd0;
    return (dim - k) / s + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_fill_control_strided_if.sv
// Memory request handshake plus FIFO-bank flags shared between the fill
// controller (master) and the image memory / FIFO bank (slave).
interface fifo_fill_control_strided_if
  import fifo_fill_pkg::*;
#(
  parameter int ARRAY_SIZE = 9,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) ();

  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ARRAY_SIZE-1:0] fifo_full;
  logic [ARRAY_SIZE-1:0] lane_we;

  modport master (
    output rd_addr, rd_valid, lane_we,
    input  rd_ready, fifo_full
  );

  modport slave (
    input  rd_addr, rd_valid, lane_we,
    output rd_ready, fifo_full
  );

endinterface

// File: rtl/fifo_fill_control_strided_lane_we_pipe.sv
// Delays the accepted lane one-hot by the memory read latency so that the
// FIFO write enable lines up with returning data.
module lane_we_pipe #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_in;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_out = r_stage[DEPTH-1];

endmodule

// File: rtl/fifo_fill_control_strided.sv
// Generates the strided, multi-channel image read stream that fills the
// per-PE input FIFOs, with valid/ready memory handshake and delayed write enables.
module fifo_fill_control_strided
  import fifo_fill_pkg::*;
#(
  parameter int ARRAY_SIZE   = 9,
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DIM_W        = DEFAULT_DIM_W,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [7:0]        kernel_size,
  input  logic [DIM_W-1:0]  image_height,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [3:0]        stride,
  input  logic [7:0]        channels,
  input  logic [ADDR_W-1:0] channel_pitch,
  input  logic [7:0]        lane_offset,
  fifo_fill_control_strided_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              cfg_error
);

  state_t r_state, w_nextState;

  logic [ADDR_W-1:0] r_base, r_pitch;
  logic [7:0]        r_k, r_c, r_off;
  logic [DIM_W-1:0]  r_h, r_w;
  logic [3:0]        r_s;

  logic [DIM_W-1:0]  r_ho, r_wo, r_oy, r_ox;
  logic [7:0]        r_ky, r_kx, r_ch, r_lane;
  logic [ADDR_W-1:0] r_strideRow, r_chBase, r_rowBase, r_winBase, r_tapRow, r_addr;
  logic              r_pending;
  logic [7:0]        r_drainCnt;

  logic                  w_illegal, w_full, w_rdValid, w_accept;
  logic                  w_lastKx, w_lastKy, w_lastOx, w_lastOy, w_lastCh, w_lastReq;
  logic [ARRAY_SIZE-1:0] w_laneOh, w_weIn;
  logic [ADDR_W-1:0]     w_colStep, w_rowStep;

  assign w_illegal = (r_k == 8'd0) || (r_s == 4'd0) || (r_c == 8'd0) ||
                     (32'(r_k) > 32'(r_h)) || (32'(r_k) > 32'(r_w)) ||
                     ((32'(r_off) + 32'(r_k) * 32'(r_k)) > 32'(ARRAY_SIZE));

  assign w_laneOh  = ARRAY_SIZE'(1) << r_lane;
  assign w_full    = |(mem.fifo_full & w_laneOh);
  // Once offered, a request is held regardless of later fifo_full changes.
  assign w_rdValid = (r_state == ST_RUN) && (r_pending || !w_full);
  assign w_accept  = w_rdValid && mem.rd_ready;

  assign w_lastKx  = (r_kx == r_k - 8'd1);
  assign w_lastKy  = (r_ky == r_k - 8'd1);
  assign w_lastOx  = (r_ox == r_wo - DIM_W'(1));
  assign w_lastOy  = (r_oy == r_ho - DIM_W'(1));
  assign w_lastCh  = (r_ch == r_c - 8'd1);
  assign w_lastReq = w_lastKx && w_lastKy && w_lastOx && w_lastOy && w_lastCh;

  assign w_colStep = ADDR_W'(r_s);
  assign w_rowStep = ADDR_W'(r_w);
  assign w_weIn    = w_accept ? w_laneOh : '0;

  assign mem.rd_addr  = r_addr;
  assign mem.rd_valid = w_rdValid;
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_FINISH);
  assign cfg_error    = (r_state == ST_SETUP) && w_illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_nextState = ST_SETUP;
      ST_SETUP:  w_nextState = w_illegal ? ST_IDLE : ST_RUN;
      ST_RUN:    if (w_accept && w_lastReq) w_nextState = ST_DRAIN;
      ST_DRAIN:  if (r_drainCnt == 8'(READ_LATENCY - 1)) w_nextState = ST_FINISH;
      ST_FINISH: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Loop counters walk tap -> column -> row -> channel; each level keeps its
  // own running address base so only adders sit on the per-request path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base <= '0;  r_pitch <= '0;  r_k <= '0;  r_c <= '0;  r_off <= '0;
      r_h <= '0;  r_w <= '0;  r_s <= '0;
      r_ho <= '0;  r_wo <= '0;  r_oy <= '0;  r_ox <= '0;
      r_ky <= '0;  r_kx <= '0;  r_ch <= '0;  r_lane <= '0;
      r_strideRow <= '0;  r_chBase <= '0;  r_rowBase <= '0;
      r_winBase <= '0;  r_tapRow <= '0;  r_addr <= '0;
      r_pending <= 1'b0;  r_drainCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= base_address;
            r_pitch <= channel_pitch;
            r_k     <= kernel_size;
            r_c     <= channels;
            r_off   <= lane_offset;
            r_h     <= image_height;
            r_w     <= image_width;
            r_s     <= stride;
          end
        end
        ST_SETUP: begin
          r_ho        <= DIM_W'(outDim(32'(r_h), 32'(r_k), 32'(r_s)));
          r_wo        <= DIM_W'(outDim(32'(r_w), 32'(r_k), 32'(r_s)));
          r_strideRow <= ADDR_W'(r_w) * ADDR_W'(r_s);
          r_oy <= '0;  r_ox <= '0;  r_ky <= '0;  r_kx <= '0;  r_ch <= '0;
          r_lane     <= r_off;
          r_chBase   <= r_base;
          r_rowBase  <= r_base;
          r_winBase  <= r_base;
          r_tapRow   <= r_base;
          r_addr     <= r_base;
          r_pending  <= 1'b0;
          r_drainCnt <= '0;
        end
        ST_RUN: begin
          if (w_accept) begin
            r_pending <= 1'b0;
            if (!w_lastKx) begin
              r_kx   <= r_kx + 8'd1;
              r_addr <= r_addr + ADDR_W'(1);
              r_lane <= r_lane + 8'd1;
            end else if (!w_lastKy) begin
              r_kx     <= '0;
              r_ky     <= r_ky + 8'd1;
              r_tapRow <= r_tapRow + w_rowStep;
              r_addr   <= r_tapRow + w_rowStep;
              r_lane   <= r_lane + 8'd1;
            end else begin
              r_kx   <= '0;
              r_ky   <= '0;
              r_lane <= r_off;
              if (!w_lastOx) begin
                r_ox      <= r_ox + DIM_W'(1);
                r_winBase <= r_winBase + w_colStep;
                r_tapRow  <= r_winBase + w_colStep;
                r_addr    <= r_winBase + w_colStep;
              end else if (!w_lastOy) begin
                r_ox      <= '0;
                r_oy      <= r_oy + DIM_W'(1);
                r_rowBase <= r_rowBase + r_strideRow;
                r_winBase <= r_rowBase + r_strideRow;
                r_tapRow  <= r_rowBase + r_strideRow;
                r_addr    <= r_rowBase + r_strideRow;
              end else if (!w_lastCh) begin
                r_ox      <= '0;
                r_oy      <= '0;
                r_ch      <= r_ch + 8'd1;
                r_chBase  <= r_chBase + r_pitch;
                r_rowBase <= r_chBase + r_pitch;
                r_winBase <= r_chBase + r_pitch;
                r_tapRow  <= r_chBase + r_pitch;
                r_addr    <= r_chBase + r_pitch;
              end
            end
          end else begin
            r_pending <= w_rdValid;
          end
        end
        ST_DRAIN: r_drainCnt <= r_drainCnt + 8'd1;
        default: ;
      endcase
    end
  end

  lane_we_pipe #(
    .WIDTH (ARRAY_SIZE),
    .DEPTH (READ_LATENCY)
  ) u_laneWePipe (
    .clk   (clk),
    .rst_n (reset),
    .i_in  (w_weIn),
    .o_out (mem.lane_we)
  );

endmodule

// File: tb/tb_fifo_fill_control_strided.sv
// Self-checking bench: expected request stream comes from plain nested loops
// over channel/row/column/tap, with random ready and fifo_full backpressure.
module tb_fifo_fill_control_strided;

  localparam int ARRAY_SIZE = 9;
  localparam int ADDR_W     = 14;
  localparam int DIM_W      = 16;
  localparam int LAT        = 2;
  localparam int NONE       = -100;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] baseAddress, channelPitch;
  logic [7:0]        kernelSize, channels, laneOffset;
  logic [DIM_W-1:0]  imageHeight, imageWidth;
  logic [3:0]        stride;
  logic              busy, done, cfgError;

  int checks   = 0;
  int failures = 0;

  fifo_fill_control_strided_if #(.ARRAY_SIZE(ARRAY_SIZE), .ADDR_W(ADDR_W)) mem ();

  fifo_fill_control_strided #(
    .ARRAY_SIZE   (ARRAY_SIZE),
    .ADDR_W       (ADDR_W),
    .DIM_W        (DIM_W),
    .READ_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_address  (baseAddress),
    .kernel_size   (kernelSize),
    .image_height  (imageHeight),
    .image_width   (imageWidth),
    .stride        (stride),
    .channels      (channels),
    .channel_pitch (channelPitch),
    .lane_offset   (laneOffset),
    .mem           (mem),
    .busy          (busy),
    .done          (done),
    .cfg_error     (cfgError)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a configuration with a start pulse, then scrambles the inputs
  // so any failure to latch them shows up. Returns at the negedge of cycle 1.
  task automatic startRun(input int base, input int k, input int h, input int w,
                          input int s, input int c, input int pitch, input int off);
    @(negedge clk);
    baseAddress  = ADDR_W'(base);
    kernelSize   = 8'(k);
    imageHeight  = DIM_W'(h);
    imageWidth   = DIM_W'(w);
    stride       = 4'(s);
    channels     = 8'(c);
    channelPitch = ADDR_W'(pitch);
    laneOffset   = 8'(off);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    baseAddress  = ADDR_W'($urandom);
    kernelSize   = 8'($urandom_range(0, 9));
    imageHeight  = DIM_W'($urandom_range(0, 9));
    imageWidth   = DIM_W'($urandom_range(0, 9));
    stride       = 4'($urandom_range(0, 4));
    channels     = 8'($urandom_range(0, 3));
    channelPitch = ADDR_W'($urandom);
    laneOffset   = 8'($urandom_range(0, 9));
  endtask

  task automatic applyStimulus(input string name, input int base, input int k,
                               input int h, input int w, input int s, input int c,
                               input int pitch, input int off, input int readyPct,
                               input int fullPct, input int stallAt, input int fullAt);
    int expAddr[$];
    int expLane[$];
    int weCyc[$];
    int weLane[$];
    int ho, wo, cyc, lastAcc, budget;
    bit hold, expValid, expDone, rdy;
    logic [ARRAY_SIZE-1:0] fullVec, expWe;

    ho = (h - k) / s + 1;
    wo = (w - k) / s + 1;
    for (int cc = 0; cc < c; cc++)
      for (int oy = 0; oy < ho; oy++)
        for (int ox = 0; ox < wo; ox++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              expAddr.push_back((base + cc * pitch + (oy * s + ky) * w + ox * s + kx) % (1 << ADDR_W));
              expLane.push_back(off + ky * k + kx);
            end
    budget = expAddr.size() * 30 + 50;

    startRun(base, k, h, w, s, c, pitch, off);
    cyc = 1; hold = 0; lastAcc = -1;
    forever begin
      start = (cyc == 5);
      if (cyc >= stallAt && cyc < stallAt + 3) rdy = 1'b0;
      else rdy = (int'($urandom_range(0, 99)) < readyPct);
      mem.rd_ready = rdy;
      fullVec = '0;
      for (int i = 0; i < ARRAY_SIZE; i++)
        if (int'($urandom_range(0, 99)) < fullPct) fullVec[i] = 1'b1;
      if (cyc >= fullAt && cyc < fullAt + 3) fullVec[4] = 1'b1;
      mem.fifo_full = fullVec;
      #1;

      expValid = (cyc >= 2) && (expAddr.size() > 0) && (hold || !fullVec[expLane[0]]);
      checkOutput({name, " rd_valid"}, 32'(mem.rd_valid), 32'(expValid));
      if (expValid) checkOutput({name, " rd_addr"}, 32'(mem.rd_addr), 32'(expAddr[0]));

      expWe = '0;
      if (weCyc.size() > 0 && weCyc[0] == cyc) begin
        expWe[weLane[0]] = 1'b1;
        void'(weCyc.pop_front());
        void'(weLane.pop_front());
      end
      checkOutput({name, " lane_we"}, 32'(mem.lane_we), 32'(expWe));

      expDone = (lastAcc >= 0) && (cyc == lastAcc + LAT + 1);
      checkOutput({name, " done"}, 32'(done), 32'(expDone));
      checkOutput({name, " busy"}, 32'(busy), 32'd1);
      checkOutput({name, " cfg_error"}, 32'(cfgError), 32'd0);

      if (expValid && rdy) begin
        weCyc.push_back(cyc + LAT);
        weLane.push_back(expLane[0]);
        void'(expAddr.pop_front());
        void'(expLane.pop_front());
        hold = 0;
        if (expAddr.size() == 0) lastAcc = cyc;
      end else begin
        hold = expValid;
      end

      if (expDone) break;
      if (cyc > budget) begin
        checks++;
        failures++;
        $error("[TB] FAIL %s timeout observed=%0d cycles expected<=%0d", name, cyc, budget);
        break;
      end
      @(negedge clk);
      cyc++;
    end

    start = 1'b0;
    @(negedge clk);
    #1;
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
    checkOutput({name, " idle done"}, 32'(done), 32'd0);
    $display("[TB] %s complete, requests=%0d", name, c * ho * wo * k * k);
  endtask

  task automatic runIllegal(input string name, input int k, input int h, input int w,
                            input int s, input int c, input int off);
    startRun(0, k, h, w, s, c, 0, off);
    mem.rd_ready  = 1'b1;
    mem.fifo_full = '0;
    #1;
    checkOutput({name, " cfg_error pulse"}, 32'(cfgError), 32'd1);
    checkOutput({name, " setup busy"}, 32'(busy), 32'd1);
    checkOutput({name, " setup rd_valid"}, 32'(mem.rd_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput({name, " cfg_error low"}, 32'(cfgError), 32'd0);
      checkOutput({name, " no request"}, 32'(mem.rd_valid), 32'd0);
      checkOutput({name, " back idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    baseAddress = '0; channelPitch = '0; kernelSize = '0; channels = '0;
    laneOffset = '0; imageHeight = '0; imageWidth = '0; stride = '0;
    mem.rd_ready  = 1'b0;
    mem.fifo_full = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset rd_addr", 32'(mem.rd_addr), 32'd0);
    checkOutput("reset rd_valid", 32'(mem.rd_valid), 32'd0);
    checkOutput("reset lane_we", 32'(mem.lane_we), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset cfg_error", 32'(cfgError), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus("basic",   0,     3, 4, 4, 1, 1, 0,    0, 100, 0,  NONE, NONE);
    applyStimulus("stride2", 0,     3, 5, 5, 2, 1, 0,    0, 100, 0,  NONE, NONE);
    applyStimulus("stall",   0,     3, 4, 4, 1, 1, 0,    0, 100, 0,  10,   NONE);
    applyStimulus("full4",   0,     3, 4, 4, 1, 1, 0,    0, 100, 0,  NONE, 6);
    applyStimulus("twoChan", 0,     3, 4, 4, 1, 2, 100,  0, 100, 0,  NONE, NONE);
    applyStimulus("wrap",    16380, 2, 5, 3, 1, 2, 9000, 5, 80,  5,  NONE, NONE);
    applyStimulus("exact",   42,    3, 3, 3, 1, 1, 0,    0, 70,  10, NONE, NONE);
    applyStimulus("k1edge",  7,     1, 2, 3, 2, 1, 0,    8, 100, 0,  NONE, NONE);

    runIllegal("k5on4x4", 5, 4, 4, 1, 1, 0);
    runIllegal("k0",      0, 4, 4, 1, 1, 0);
    runIllegal("s0",      3, 4, 4, 0, 1, 0);
    runIllegal("c0",      3, 4, 4, 1, 0, 0);
    runIllegal("lanes",   3, 4, 4, 1, 1, 1);
    runIllegal("kGtW",    3, 8, 2, 1, 1, 0);

    startRun(0, 3, 4, 4, 1, 1, 0, 0);
    mem.rd_ready  = 1'b1;
    mem.fifo_full = '0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset rd_addr", 32'(mem.rd_addr), 32'd0);
    checkOutput("midreset rd_valid", 32'(mem.rd_valid), 32'd0);
    checkOutput("midreset lane_we", 32'(mem.lane_we), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset cfg_error", 32'(cfgError), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checkOutput("postreset lane_we", 32'(mem.lane_we), 32'd0);
      checkOutput("postreset rd_valid", 32'(mem.rd_valid), 32'd0);
      checkOutput("postreset busy", 32'(busy), 32'd0);
    end

    applyStimulus("recover", 0, 3, 4, 4, 1, 1, 0, 0, 100, 0, NONE, NONE);

    for (int i = 0; i < 6; i++) begin
      int k, h, w, s, c, off;
      k   = $urandom_range(1, 3);
      h   = $urandom_range(k, 7);
      w   = $urandom_range(k, 7);
      s   = $urandom_range(1, 3);
      c   = $urandom_range(1, 2);
      off = $urandom_range(0, ARRAY_SIZE - k * k);
      applyStimulus($sformatf("rand%0d", i), int'($urandom_range(0, 16383)), k, h, w, s, c,
                    int'($urandom_range(0, 16383)), off, int'($urandom_range(50, 100)),
                    int'($urandom_range(0, 15)), NONE, NONE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
